// File: rtl/ptm_writer.sv
// ptm_writer: fills the pattern memory image that the pattern-matching reader consumes.
// Memory layout: address 0 holds the stream length N. Addresses 1..N hold one bit each,
// in data[0], with all upper bits zero.
// Bits arrive over a valid/ready handshake. Each accepted bit is written to the next
// address. The length header is written last, and then done pulses for one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      begins a session (sampled only in IDLE)
//   bit_valid  bit_in is presented
//   bit_in     serial pattern bit
//   last       marks the accepted bit as the final one
//   flush      ends the session without a bit
//   bit_ready  writer can accept a bit (state FILL)
//   wen        memory write strobe, one cycle per write
//   waddr      memory write address (held when wen=0)
//   wdata      memory write data (held when wen=0)
//   busy       session in progress (FILL or HDR)
//   done       one-cycle completion pulse, after the header write
//   length     bits written in the last completed session
//   overflow   sticky: session ended by capacity; cleared on next start
module ptm_writer #(
  parameter int unsigned datawidth = 10,
  parameter int unsigned memwidth  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 last,
  input  logic                 flush,
  output logic                 bit_ready,
  output logic                 wen,
  output logic [memwidth-1:0]  waddr,
  output logic [datawidth-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [memwidth-1:0]  length,
  output logic                 overflow
);

  localparam logic [memwidth-1:0] MAXLEN = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HDR  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [memwidth-1:0] count;
  logic [memwidth-1:0] count_inc;

  assign count_inc = count + memwidth'(1);

  // Handshake and status flags decode directly from the registered state
  assign bit_ready = (state == FILL);
  assign busy      = (state == FILL) || (state == HDR);

  // Session sequencer, write port and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      wen      <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      done     <= 1'b0;
      length   <= '0;
      overflow <= 1'b0;
    end else begin
      wen  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count    <= '0;
            overflow <= 1'b0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (bit_valid) begin
            count <= count_inc;
            wen   <= 1'b1;
            waddr <= count_inc;
            wdata <= {{(datawidth-1){1'b0}}, bit_in};
            // last takes priority over capacity, so overflow stays clear when both coincide
            if (last) begin
              state <= HDR;
            end else if (count_inc == MAXLEN) begin
              overflow <= 1'b1;
              state    <= HDR;
            end else if (flush) begin
              state <= HDR;
            end
          end else if (flush) begin
            state <= HDR;
          end
        end
        HDR: begin
          wen    <= 1'b1;
          waddr  <= '0;
          wdata  <= datawidth'(count);
          length <= count;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
